// File: rtl/bmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bmem_pkg
// Purpose  : Shared constants and types for the bmem line adapter slice.
// Revision : 1.0 - initial release
// ============================================================================
package bmem_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = 4;
  localparam int OFFSET_W = 5;
  localparam int CNT_W    = $clog2(BEATS);

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WR   = 1'b1
  } bmem_iss_state_t;

endpackage
`default_nettype wire

// File: rtl/bmem_line_assembler.sv
`default_nettype none
// ============================================================================
// Module   : bmem_line_assembler
// Purpose  : Collects four contiguous read beats into one line, captures the
//            burst address at beat 0 and pulses line_done the cycle after the
//            last beat, with the finished line and its tag.
// Revision : 1.0 - initial release
// ============================================================================
module bmem_line_assembler
  import bmem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rvalid,
  input  logic [BEAT_W-1:0] rdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic              line_done,
  output line_t             line,
  output logic [ADDR_W-1:0] tag
);

  logic [CNT_W-1:0]  r_rcnt;
  line_t             r_line;
  logic [ADDR_W-1:0] r_tag;
  logic              r_done;

  // Beat k lands in slice k; the counter wraps so back-to-back bursts line up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rcnt <= '0;
      r_line <= '0;
      r_tag  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= rvalid && (r_rcnt == CNT_W'(BEATS-1));
      if (rvalid) begin
        r_line[r_rcnt*BEAT_W +: BEAT_W] <= rdata;
        if (r_rcnt == '0) begin
          r_tag <= raddr;
        end
        r_rcnt <= r_rcnt + 1'b1;
      end
    end
  end

  assign line_done = r_done;
  assign line      = r_line;
  assign tag       = r_tag;

endmodule
`default_nettype wire

// File: rtl/bmem_line_adapter.sv
`default_nettype none
// ============================================================================
// Module   : bmem_line_adapter
// Purpose  : Turns I-cache / D-cache line requests into 64-bit bmem bursts,
//            arbitrates between the two clients round-robin, and routes each
//            reassembled read line back to whichever client it belongs to.
// Revision : 1.0 - initial release
// ============================================================================
module bmem_line_adapter
  import bmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_read,
  output line_t             ic_rdata,
  output logic              ic_resp,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_read,
  input  logic              dc_write,
  input  line_t             dc_wdata,
  output line_t             dc_rdata,
  output logic              dc_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int WCNT_W = $clog2(BEATS);

  bmem_iss_state_t   r_state;
  logic [WCNT_W-1:0] r_wcnt;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_ic_issued;
  logic              r_dc_issued;
  logic              r_rr;          // 0: I-cache wins a tie, 1: D-cache wins
  logic              r_dc_wr_resp;

  logic              w_line_done;
  line_t             w_line;
  logic [ADDR_W-1:0] w_tag;

  logic              w_ic_done;
  logic              w_dc_done;
  logic              w_ic_pend;
  logic              w_dc_pend;
  logic              w_pick_dc;
  logic              w_grant;
  logic              w_grant_ic;
  logic              w_grant_dc;
  logic              w_grant_wr;
  logic [ADDR_W-1:0] w_grant_addr;
  logic              w_unused;

  bmem_line_assembler #(
    .ADDR_W (ADDR_W)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .rvalid    (bmem_rvalid),
    .rdata     (bmem_rdata),
    .raddr     (bmem_raddr),
    .line_done (w_line_done),
    .line      (w_line),
    .tag       (w_tag)
  );

  // A finished line completes every issued client whose line address matches.
  assign w_ic_done = w_line_done && r_ic_issued &&
                     (ic_addr[ADDR_W-1:OFFSET_W] == w_tag[ADDR_W-1:OFFSET_W]);
  assign w_dc_done = w_line_done && r_dc_issued &&
                     (dc_addr[ADDR_W-1:OFFSET_W] == w_tag[ADDR_W-1:OFFSET_W]);

  // The request is still held during its own response cycle, so mask it there.
  assign w_ic_pend = ic_read && !r_ic_issued && !w_ic_done;
  assign w_dc_pend = (dc_read || dc_write) && !r_dc_issued && !w_dc_done &&
                     !r_dc_wr_resp && (r_state == IDLE);

  assign w_pick_dc    = w_dc_pend && (!w_ic_pend || r_rr);
  assign w_grant      = !rst && (r_state == IDLE) && bmem_ready && (w_ic_pend || w_dc_pend);
  assign w_grant_ic   = w_grant && !w_pick_dc;
  assign w_grant_dc   = w_grant && w_pick_dc;
  assign w_grant_wr   = w_grant_dc && dc_write;
  assign w_grant_addr = w_pick_dc ? {dc_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}}
                                  : {ic_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

  assign w_unused = ^{ic_addr[OFFSET_W-1:0], dc_addr[OFFSET_W-1:0], w_tag[OFFSET_W-1:0]};

  // Command bus: a read is a single cycle; a write shows beat 0 on the grant
  // cycle and the remaining beats from WR, holding a beat while ready is low.
  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    if (r_state == WR) begin
      bmem_write = 1'b1;
      bmem_addr  = r_waddr;
      bmem_wdata = dc_wdata[r_wcnt*BEAT_W +: BEAT_W];
    end else if (w_grant) begin
      bmem_addr = w_grant_addr;
      if (w_grant_wr) begin
        bmem_write = 1'b1;
        bmem_wdata = dc_wdata[BEAT_W-1:0];
      end else begin
        bmem_read = 1'b1;
      end
    end
  end

  // Issue FSM, issued flags and the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wcnt       <= '0;
      r_waddr      <= '0;
      r_ic_issued  <= 1'b0;
      r_dc_issued  <= 1'b0;
      r_rr         <= 1'b0;
      r_dc_wr_resp <= 1'b0;
    end else begin
      r_dc_wr_resp <= 1'b0;
      if (w_ic_done)  r_ic_issued <= 1'b0;
      if (w_grant_ic) r_ic_issued <= 1'b1;
      if (w_dc_done)  r_dc_issued <= 1'b0;
      if (w_grant_dc && !dc_write) r_dc_issued <= 1'b1;
      if (w_grant && w_ic_pend && w_dc_pend) r_rr <= ~r_rr;
      case (r_state)
        IDLE: begin
          if (w_grant_wr) begin
            r_state <= WR;
            r_wcnt  <= WCNT_W'(1);
            r_waddr <= w_grant_addr;
          end
        end
        WR: begin
          if (bmem_ready) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == WCNT_W'(BEATS-1)) begin
              r_state      <= IDLE;
              r_dc_wr_resp <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ic_resp  = w_ic_done;
  assign ic_rdata = w_ic_done ? w_line : '0;
  assign dc_resp  = w_dc_done || r_dc_wr_resp;
  assign dc_rdata = w_dc_done ? w_line : '0;

endmodule
`default_nettype wire

// File: tb/tb_bmem_line_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bmem_line_adapter
// Purpose  : Directed self-checking bench for bmem_line_adapter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bmem_line_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  ic_addr, dc_addr;
  logic         ic_read, dc_read, dc_write;
  logic [255:0] ic_rdata, dc_rdata, dc_wdata;
  logic         ic_resp, dc_resp;
  logic [31:0]  bmem_addr, bmem_raddr;
  logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0]  bmem_wdata, bmem_rdata;

  bmem_line_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .ic_addr     (ic_addr),
    .ic_read     (ic_read),
    .ic_rdata    (ic_rdata),
    .ic_resp     (ic_resp),
    .dc_addr     (dc_addr),
    .dc_read     (dc_read),
    .dc_write    (dc_write),
    .dc_wdata    (dc_wdata),
    .dc_rdata    (dc_rdata),
    .dc_resp     (dc_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // bus monitor, sampled mid-cycle
  int           n_rd = 0, n_wr = 0, n_stall = 0, n_ic = 0, n_dc = 0;
  logic [31:0]  rd_log      [0:31];
  logic [63:0]  wr_log      [0:31];
  logic [31:0]  wr_addr_log [0:31];
  logic [63:0]  stall_data;

  always @(negedge clk) begin
    if (bmem_read) begin
      rd_log[n_rd[4:0]] <= bmem_addr;
      n_rd <= n_rd + 1;
    end
    if (bmem_write && bmem_ready) begin
      wr_log[n_wr[4:0]]      <= bmem_wdata;
      wr_addr_log[n_wr[4:0]] <= bmem_addr;
      n_wr <= n_wr + 1;
    end
    if (bmem_write && !bmem_ready) begin
      stall_data <= bmem_wdata;
      n_stall    <= n_stall + 1;
    end
    if (ic_resp) n_ic <= n_ic + 1;
    if (dc_resp) n_dc <= n_dc + 1;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // four contiguous beats; returns 1ns into the cycle after the last beat
  task automatic send_burst(input logic [31:0] a, input logic [255:0] l);
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = a;
      bmem_rdata  = l[k*64 +: 64];
      tick();
    end
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    #1;
  endtask

  logic [255:0] l1, wl, l3i, l3d, l5, l6, l4, l4b, wl6;
  int b, bw, bs, i0, d0;

  initial begin
    l1  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    wl  = {64'hD4D4_D4D4_D4D4_D4D4, 64'hC3C3_C3C3_C3C3_C3C3,
           64'hB2B2_B2B2_B2B2_B2B2, 64'hA1A1_A1A1_A1A1_A1A1};
    l3i = {64'h0103, 64'h0102, 64'h0101, 64'h0100};
    l3d = {64'h0203, 64'h0202, 64'h0201, 64'h0200};
    l5  = {64'h0503, 64'h0502, 64'h0501, 64'h0500};
    l6  = {64'h0603, 64'h0602, 64'h0601, 64'h0600};
    l4  = {64'h0303, 64'h0302, 64'h0301, 64'h0300};
    l4b = {64'hEE03, 64'hEE02, 64'hEE01, 64'hEE00};
    wl6 = {64'h7777_0003, 64'h7777_0002, 64'h7777_0001, 64'h7777_0000};

    rst = 1'b1; ic_addr = '0; dc_addr = '0; ic_read = 0; dc_read = 0; dc_write = 0;
    dc_wdata = '0; bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 0;
    ic_read = 1'b1; // a request during reset must not leak onto the bus
    tick(); tick();
    check("rst_bmem_read", bmem_read, 0);
    check("rst_bmem_write", bmem_write, 0);
    check("rst_bmem_addr", bmem_addr, 0);
    check("rst_ic_resp", ic_resp, 0);
    check("rst_dc_resp", dc_resp, 0);
    check("rst_ic_rdata", ic_rdata, 0);
    ic_read = 1'b0;
    rst = 1'b0;

    // ---- IC read 0x1024 ----
    b = n_rd; i0 = n_ic;
    ic_addr = 32'h0000_1024; ic_read = 1'b1;
    repeat (3) tick();
    send_burst(32'h0000_1020, l1);
    check("t1_ic_resp", ic_resp, 1);
    check("t1_ic_rdata", ic_rdata, l1);
    check("t1_dc_resp", dc_resp, 0);
    tick(); ic_read = 1'b0; tick();
    check("t1_n_read", n_rd - b, 1);
    check("t1_rd_addr", rd_log[b], 32'h0000_1020);
    check("t1_n_ic_resp", n_ic - i0, 1);

    // ---- DC write 0x8000_0040, stall on beat 2 ----
    bw = n_wr; bs = n_stall; d0 = n_dc; b = n_rd;
    dc_addr = 32'h8000_0040; dc_wdata = wl; dc_write = 1'b1;
    tick();
    tick(); bmem_ready = 1'b0;
    tick(); tick();
    tick(); bmem_ready = 1'b1;
    tick();
    tick(); #1;
    check("t2_dc_resp", dc_resp, 1);
    tick(); dc_write = 1'b0; tick();
    check("t2_n_beats", n_wr - bw, 4);
    for (int k = 0; k < 4; k++) check("t2_beat", wr_log[bw+k], wl[k*64 +: 64]);
    check("t2_addr", wr_addr_log[bw+3], 32'h8000_0040);
    check("t2_n_stall", n_stall - bs, 3);
    check("t2_stall_data", stall_data, wl[191:128]);
    check("t2_n_dc_resp", n_dc - d0, 1);
    check("t2_no_read", n_rd - b, 0);

    // ---- IC 0x100 + DC 0x200 together, DC answered first ----
    b = n_rd;
    ic_addr = 32'h100; ic_read = 1'b1; dc_addr = 32'h200; dc_read = 1'b1;
    repeat (3) tick();
    send_burst(32'h200, l3d);
    check("t3_dc_resp", dc_resp, 1);
    check("t3_ic_quiet", ic_resp, 0);
    check("t3_dc_rdata", dc_rdata, l3d);
    tick(); dc_read = 1'b0;
    send_burst(32'h100, l3i);
    check("t3_ic_resp", ic_resp, 1);
    check("t3_ic_rdata", ic_rdata, l3i);
    tick(); ic_read = 1'b0; tick();
    check("t3_n_read", n_rd - b, 2);
    check("t3_first", rd_log[b], 32'h100);
    check("t3_second", rd_log[b+1], 32'h200);

    // ---- second tie: pointer has moved, DC goes first ----
    b = n_rd;
    ic_addr = 32'h500; ic_read = 1'b1; dc_addr = 32'h600; dc_read = 1'b1;
    repeat (3) tick();
    send_burst(32'h500, l5);
    check("t3b_ic_rdata", ic_rdata, l5);
    tick(); ic_read = 1'b0;
    send_burst(32'h600, l6);
    check("t3b_dc_rdata", dc_rdata, l6);
    tick(); dc_read = 1'b0; tick();
    check("t3b_first", rd_log[b], 32'h600);
    check("t3b_second", rd_log[b+1], 32'h500);

    // ---- both read 0x300 ----
    b = n_rd; i0 = n_ic; d0 = n_dc;
    ic_addr = 32'h300; dc_addr = 32'h300; ic_read = 1'b1; dc_read = 1'b1;
    repeat (3) tick();
    send_burst(32'h300, l4);
    check("t4_ic_resp", ic_resp, 1);
    check("t4_dc_resp", dc_resp, 1);
    check("t4_ic_rdata", ic_rdata, l4);
    check("t4_dc_rdata", dc_rdata, l4);
    tick(); ic_read = 1'b0; dc_read = 1'b0;
    send_burst(32'h300, l4b);
    check("t4_stale_ic", ic_resp, 0);
    check("t4_stale_dc", dc_resp, 0);
    tick();
    check("t4_n_read", n_rd - b, 2);
    check("t4_n_ic", n_ic - i0, 1);
    check("t4_n_dc", n_dc - d0, 1);

    // ---- reset during WR beat 1, stale burst, then fresh IC read ----
    i0 = n_ic; d0 = n_dc;
    dc_addr = 32'h9000_0000; dc_wdata = wl; dc_write = 1'b1;
    tick();
    #2 rst = 1'b1; #1;
    check("t5_write_drop", bmem_write, 0);
    check("t5_addr_drop", bmem_addr, 0);
    check("t5_wdata_drop", bmem_wdata, 0);
    dc_write = 1'b0;
    tick(); tick(); rst = 1'b0;
    send_burst(32'h9000_0000, l4b);
    check("t5_stale_ic", ic_resp, 0);
    check("t5_stale_dc", dc_resp, 0);
    tick();
    check("t5_n_ic", n_ic - i0, 0);
    check("t5_n_dc", n_dc - d0, 0);
    b = n_rd;
    ic_addr = 32'h700; ic_read = 1'b1;
    repeat (3) tick();
    send_burst(32'h700, l5);
    check("t5_ic_resp", ic_resp, 1);
    check("t5_ic_rdata", ic_rdata, l5);
    tick(); ic_read = 1'b0; tick();
    check("t5_n_read", n_rd - b, 1);

    // ---- DC write overlapping an IC read burst ----
    i0 = n_ic; d0 = n_dc; bw = n_wr;
    ic_addr = 32'h2000; ic_read = 1'b1;
    tick();
    dc_addr = 32'hA000_0000; dc_wdata = wl6; dc_write = 1'b1;
    send_burst(32'h2000, l6);
    check("t6_ic_resp", ic_resp, 1);
    check("t6_dc_resp", dc_resp, 1);
    check("t6_ic_rdata", ic_rdata, l6);
    tick(); ic_read = 1'b0; dc_write = 1'b0; tick();
    check("t6_n_beats", n_wr - bw, 4);
    check("t6_beat3", wr_log[bw+3], wl6[255:192]);
    check("t6_addr", wr_addr_log[bw], 32'hA000_0000);
    check("t6_n_ic", n_ic - i0, 1);
    check("t6_n_dc", n_dc - d0, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bmem_line_adapter.md
Name: bmem_line_adapter

Overview:
- CPU-side initiator of the banked-memory interface. Converts 256-bit cache-line read and writeback requests from the I-cache and D-cache into 64-bit bmem bursts.
- Reassembles returned read beats into lines and routes each completed line back to its requesting client.
- Sits inside `cpu` between the two caches and the top-level `bmem_*` ports.

Parameters:
- ADDR_W, 32, byte address width.
- BEAT_W, 64, bmem data beat width.
- BEATS, 4, beats per cache line (line = BEATS*BEAT_W = 256 bits; offset bits = 5).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ic_addr  in  32  I-cache line address; low 5 bits ignored
- ic_read  in  1  I-cache read request; held with ic_addr stable until ic_resp
- ic_rdata  out  256  returned line; valid only while ic_resp=1
- ic_resp  out  1  one-cycle completion pulse
- dc_addr  in  32  D-cache line address
- dc_read  in  1  D-cache read request; held until dc_resp
- dc_write  in  1  D-cache writeback request; held until dc_resp; never asserted together with dc_read
- dc_wdata  in  256  writeback line; beat k = dc_wdata[64k+63:64k]
- dc_rdata  out  256  returned line
- dc_resp  out  1  one-cycle completion pulse (read or write)
- bmem_addr  out  32  line-aligned burst address
- bmem_read  out  1  read command, one cycle per line
- bmem_write  out  1  write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory accepts a command or beat this cycle
- bmem_raddr  in  32  address tag of the returning read burst
- bmem_rdata  in  64  read beat data
- bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset: all outputs 0. Issued flags, beat counters, buffers and round-robin pointer all cleared. Applies immediately on rst rising, independent of clk.
- Addresses: bmem_addr = {addr[31:5], 5'b0}. Route matching compares bits [31:5] only.
- Per-client state, tracked separately for ic and dc: pending = request asserted and not yet issued; issued = command sent, awaiting completion.
- Issue FSM states:
  - IDLE: choose among pending clients. If both are pending, round-robin picks one and the pointer toggles after the grant.
  - IDLE with a read chosen and bmem_ready=1: drive bmem_read=1 and bmem_addr for exactly one cycle, set that client's issued flag, stay in IDLE.
  - IDLE with dc write chosen and bmem_ready=1: go to WR. Beat 0 is driven in the same cycle the grant is taken.
  - WR: bmem_write=1, bmem_addr held, bmem_wdata = beat[wcnt]. wcnt advances only on cycles with bmem_ready=1; when ready=0, the same beat is held.
  - WR exit: after beat 3 is accepted, return to IDLE and pulse dc_resp on the next cycle.
  - bmem_ready=0 in IDLE: no command issued; the grant is re-evaluated next cycle.
- Outstanding limit: at most one read per client, so up to 2 reads in flight.
- Read response rules:
  - Bursts arrive as 4 contiguous rvalid beats, never interleaved.
  - Responses may return out of order relative to issue.
  - rcnt counts beats 0..3 and wraps to 0. Beat k is written to line buffer slice k.
  - bmem_raddr is captured at beat 0.
- Completion, the cycle after beat 3:
  - Issued ic read whose address matches the captured raddr: ic_resp=1, ic_rdata=buffer.
  - Issued dc read that matches: dc_resp=1, dc_rdata=buffer.
  - Both match: pulse both in the same cycle.
  - Neither matches (stale burst after reset): beats are consumed and no response is produced.
  - Completion clears the matching client's issued flag.
- Simultaneous events:
  - A read burst may be received while WR is driving write beats; both proceed independently.
  - dc_resp for a write and ic_resp for a read may pulse in the same cycle.
  - A client may re-request in the cycle after its resp. It is treated as new pending and is not re-matched to the old burst.
- Latency: fastest read is 1 cycle issue + memory latency + 4 beats + 1 cycle resp. Write is 4 beats + 1 cycle resp when ready stays high.
- Reset mid-burst: the WR burst is abandoned and bmem_write drops asynchronously. Any read beats still arriving are consumed with no response.

Decomposition:
- Shared package `bmem_pkg`:
  - LINE_W, BEAT_W, BEATS, OFFSET_W constants.
  - Typedef `line_t` as logic [255:0].
  - Enum `bmem_iss_state_t` {IDLE, WR}.
- One sub-module, `bmem_line_assembler`: rcnt, raddr capture, line buffer, and a one-cycle `line_done` pulse with line and tag outputs.
- Top level holds the issue FSM, arbitration and routing.

Test Plan:
- IC read at 0x0000_1024, memory returns beats 0x11..,0x22..,0x33..,0x44.. with raddr 0x1020 → exactly one bmem_read with bmem_addr=0x0000_1020; ic_rdata={0x44..,0x33..,0x22..,0x11..} and ic_resp high for 1 cycle after beat 3.
- DC write to 0x8000_0040 with bmem_ready low on beat 2 for 3 cycles → 4 bmem_write beats in order, beat 2 held during the stall; dc_resp 1 cycle after the 4th accepted beat.
- IC read 0x100 and DC read 0x200 pending together, memory answers 0x200 first → 2 read commands, round-robin order; dc_resp arrives before ic_resp with the correct data for each.
- IC and DC both read 0x300 → two commands issued; the first burst pulses ic_resp and dc_resp together; the second burst is consumed without a response.
- rst asserted during WR beat 1, then a stale 4-beat burst arrives → outputs 0 immediately; no resp pulses; a new IC read afterwards completes normally.
- DC write and IC read burst overlap → write beats and read beats proceed concurrently; both resps appear, possibly in the same cycle.
